// File: rtl/csa_pipe_adder_pkg.sv
// ---------------------------------------------------------------------------
// csa_pipe_adder_pkg
// Shared elaboration helpers for the pipelined carry-select adder:
//   ceil_div   - integer ceiling divide, guarded against a zero divisor
//   calc_nblk  - number of carry-select blocks for a given width
//   calc_lat   - number of pipeline stages (blocks per stage rounded up)
//   params_ok  - legality check of the WIDTH/BLOCK/BPS combination
// No ports (package).
// ---------------------------------------------------------------------------
package csa_pipe_adder_pkg;

   function automatic int ceil_div(input int n, input int d);
      return (d < 1) ? 1 : (n + d - 1) / d;
   endfunction

   function automatic int calc_nblk(input int width, input int block);
      return (block < 1) ? 1 : width / block;
   endfunction

   function automatic int calc_lat(input int nblk, input int bps);
      return ceil_div(nblk, bps);
   endfunction

   function automatic bit params_ok(input int width, input int block, input int bps);
      return (block >= 1) && (width >= block) && (width % block == 0) && (bps >= 1);
   endfunction

endpackage

// File: rtl/csa_pipe_adder_if.sv
// ---------------------------------------------------------------------------
// csa_pipe_adder_if
// Operand/result bus of the pipelined adder with valid/ready on both sides.
//   in_valid/in_ready    operand beat handshake
//   a, b, c_in, sub      operands, carry-in (add only), subtract select
//   out_valid/out_ready  result beat handshake
//   sum, c_out, ovf      result, carry out of MSB, signed overflow
// Modports: master = producer of operands / consumer of results,
//           slave  = the adder itself.
// ---------------------------------------------------------------------------
interface csa_pipe_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;

   modport master (
      output in_valid, a, b, c_in, sub, out_ready,
      input  in_ready, out_valid, sum, c_out, ovf
   );

   modport slave (
      input  in_valid, a, b, c_in, sub, out_ready,
      output in_ready, out_valid, sum, c_out, ovf
   );
endinterface

// File: rtl/csa_pipe_adder_select.sv
// ---------------------------------------------------------------------------
// csa_select_block
// One carry-select block: two ripple adders (carry-in 0 and 1) computed in
// parallel, the incoming block carry picks the sum bits and carry-out.
//   a_i, b_i  BLOCK-bit operand slices (b already inverted for subtract)
//   c_i       incoming block carry (select)
//   sum_o     selected sum bits
//   c_o       selected block carry-out
// ---------------------------------------------------------------------------
module csa_select_block #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a_i,
   input  logic [BLOCK-1:0] b_i,
   input  logic             c_i,
   output logic [BLOCK-1:0] sum_o,
   output logic             c_o
);

   // Returns {carry_out, sum} of a plain ripple adder.
   function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] a,
                                             input logic [BLOCK-1:0] b,
                                             input logic             cin);
      logic [BLOCK:0] r;
      logic           c;
      // NOTE: blocking assignments here: each bit's carry must be visible to
      // the next loop iteration, which is exactly a ripple chain.
      c = cin;
      r = '0;
      for (int i = 0; i < BLOCK; i++) begin
         r[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      r[BLOCK] = c;
      return r;
   endfunction

   logic [BLOCK:0] r0;
   logic [BLOCK:0] r1;

   assign r0    = ripple(a_i, b_i, 1'b0);
   assign r1    = ripple(a_i, b_i, 1'b1);
   assign sum_o = c_i ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
   assign c_o   = c_i ? r1[BLOCK]     : r0[BLOCK];

endmodule

// File: rtl/csa_pipe_adder.sv
// ---------------------------------------------------------------------------
// csa_pipe_adder
// Pipelined carry-select adder/subtractor, LAT = ceil(NBLK/BPS) stages, each
// stage resolving BPS blocks from the previous stage's registered carry.
// Stage registers form a skewed pipeline: one word holds the resolved sum
// bits in its low part and the not-yet-consumed 'a' bits above them; the
// unconsumed b' bits ride in a separate register that shrinks per stage.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   io   csa_pipe_adder_if.slave bus (operand and result handshakes)
// The last stage register drives sum/c_out/ovf/out_valid directly.
// ---------------------------------------------------------------------------
module csa_pipe_adder
   import csa_pipe_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int BLOCK = 4,
   parameter int BPS   = 2
) (
   input  logic              clk,
   input  logic              rst,
   csa_pipe_adder_if.slave   io
);

   localparam int NBLK = calc_nblk(WIDTH, BLOCK);
   localparam int LAT  = calc_lat(NBLK, BPS);

   if (!params_ok(WIDTH, BLOCK, BPS)) begin : g_bad_params
      $error("csa_pipe_adder: WIDTH must be a multiple of BLOCK and BPS >= 1");
   end

   for (genvar k = 0; k < LAT; k++) begin : g_st
      localparam int LO  = k * BPS;
      localparam int HI  = ((k + 1) * BPS < NBLK) ? (k + 1) * BPS : NBLK;
      localparam int NB  = HI - LO;              // blocks resolved here
      localparam int LSB = LO * BLOCK;           // first bit resolved here
      localparam int REM = WIDTH - HI * BLOCK;   // b' bits still to consume

      logic                 v_in;
      logic                 c0;
      logic [WIDTH-1:0]     x_in;
      logic [WIDTH-LSB-1:0] b_in;
      logic [NB*BLOCK-1:0]  s_blk;
      logic [WIDTH-1:0]     x_d;
      logic                 v_q;
      logic                 cy_q;
      logic [WIDTH-1:0]     x_q;
      logic                 rdy;

      if (k == 0) begin : g_src
         assign v_in = io.in_valid;
         assign x_in = io.a;
         assign b_in = io.sub ? ~io.b : io.b;
         assign c0   = io.sub | io.c_in;   // sub forces carry-in 1, c_in ignored
      end else begin : g_src
         assign v_in = g_st[k-1].v_q;
         assign x_in = g_st[k-1].x_q;
         assign b_in = g_st[k-1].g_keep.b_q;
         assign c0   = g_st[k-1].cy_q;
      end

      // Per-block carries are separate scalars so the chain is not one
      // self-referencing vector.
      for (genvar j = 0; j < NB; j++) begin : g_blk
         logic ci;
         logic co;
         if (j == 0) begin : g_ci
            assign ci = c0;
         end else begin : g_ci
            assign ci = g_blk[j-1].co;
         end
         csa_select_block #(.BLOCK(BLOCK)) u_blk (
            .a_i   (x_in[LSB + j*BLOCK +: BLOCK]),
            .b_i   (b_in[j*BLOCK +: BLOCK]),
            .c_i   (ci),
            .sum_o (s_blk[j*BLOCK +: BLOCK]),
            .c_o   (co)
         );
      end

      always_comb begin
         // NOTE: x_d takes a full default before the partial overwrite, so no
         // latch is inferred.
         x_d                     = x_in;
         x_d[LSB +: NB*BLOCK]    = s_blk;
      end

      // Combinational ready chain: a stage can load if it is empty or its
      // downstream neighbour is loading this same edge.
      if (k == LAT - 1) begin : g_rdy
         assign rdy = !v_q || io.out_ready;
      end else begin : g_rdy
         assign rdy = !v_q || g_st[k+1].rdy;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            // NOTE: datapath registers are reset as well as valid, since the
            // last stage drives sum/c_out/ovf and those must read 0 out of reset.
            v_q  <= 1'b0;
            cy_q <= 1'b0;
            x_q  <= '0;
         end else if (rdy) begin
            // NOTE: non-blocking updates, so every stage samples its upstream
            // neighbour's pre-edge value and beats advance one stage per edge.
            v_q <= v_in;
            if (v_in) begin
               x_q  <= x_d;
               cy_q <= g_blk[NB-1].co;
            end
         end
      end

      if (REM > 0) begin : g_keep
         logic [REM-1:0] b_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               b_q <= '0;
            end else if (rdy && v_in) begin
               b_q <= b_in[WIDTH-LSB-1 : NB*BLOCK];
            end
         end
      end else begin : g_fin
         // Carry into the MSB is a ^ b' ^ sum at that bit; overflow is that
         // carry XOR the carry out of the MSB.
         logic ovf_d;
         logic ovf_q;
         assign ovf_d = x_in[WIDTH-1] ^ b_in[WIDTH-LSB-1] ^ s_blk[NB*BLOCK-1]
                        ^ g_blk[NB-1].co;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (rdy && v_in) begin
               ovf_q <= ovf_d;
            end
         end
      end
   end

   assign io.in_ready  = g_st[0].rdy;
   assign io.out_valid = g_st[LAT-1].v_q;
   assign io.sum       = g_st[LAT-1].x_q;
   assign io.c_out     = g_st[LAT-1].cy_q;
   assign io.ovf       = g_st[LAT-1].g_fin.ovf_q;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_csa_pipe_adder
// Scoreboard bench: expected results are pushed when a beat is accepted and
// popped when the matching DUT result transfers. Three instances: the
// default 32/4/2 (LAT 4), 16/4/4 (LAT 1) and 24/4/4 (LAT 2, remainder stage).
// ---------------------------------------------------------------------------
module tb_csa_pipe_adder;

   typedef struct packed {
      logic [31:0] sum;
      logic        c;
      logic        v;
   } exp_t;

   localparam int LAT_M = 4;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   exp_t q_m[$];
   exp_t q16[$];
   exp_t q24[$];
   int   n_out;
   int   occ;
   logic stalled;
   exp_t held;

   csa_pipe_adder_if #(.WIDTH(32)) m ();
   csa_pipe_adder_if #(.WIDTH(16)) s16 ();
   csa_pipe_adder_if #(.WIDTH(24)) s24 ();

   csa_pipe_adder #(.WIDTH(32), .BLOCK(4), .BPS(2)) u_m   (.clk(clk), .rst(rst), .io(m));
   csa_pipe_adder #(.WIDTH(16), .BLOCK(4), .BPS(4)) u_s16 (.clk(clk), .rst(rst), .io(s16));
   csa_pipe_adder #(.WIDTH(24), .BLOCK(4), .BPS(4)) u_s24 (.clk(clk), .rst(rst), .io(s24));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference: a + b' + cin evaluated at 64 bits, overflow from sign rules.
   function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic ci, input logic sb);
      logic [63:0] mask;
      logic [63:0] bb;
      logic [63:0] full;
      exp_t        e;
      mask  = (64'd1 << w) - 64'd1;
      bb    = sb ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
      full  = ({32'd0, a} & mask) + bb + {63'd0, (sb | ci)};
      e.sum = full[31:0] & mask[31:0];
      e.c   = full[w];
      e.v   = (a[w-1] == bb[w-1]) && (full[w-1] != a[w-1]);
      return e;
   endfunction

   // ---------------- main DUT monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      logic exp_rdy;
      if (rst) begin
         q_m.delete();
         occ     = 0;
         stalled = 1'b0;
      end else begin
         exp_rdy = !(occ == LAT_M && !m.out_ready);
         total++;
         if (m.in_ready !== exp_rdy) begin
            bad++;
            $display("FAIL in_ready: got %b want %b (occupancy %0d)", m.in_ready, exp_rdy, occ);
         end
         if (stalled) begin
            total++;
            if ({m.out_valid, m.sum, m.c_out, m.ovf} !== {1'b1, held.sum, held.c, held.v}) begin
               bad++;
               $display("FAIL stall_hold: got v=%b sum=%h c=%b o=%b want v=1 sum=%h c=%b o=%b",
                        m.out_valid, m.sum, m.c_out, m.ovf, held.sum, held.c, held.v);
            end
         end
         if (m.out_valid && m.out_ready) begin
            total++;
            if (q_m.size() == 0) begin
               bad++;
               $display("FAIL unexpected_beat: got sum=%h want no beat", m.sum);
            end else begin
               e = q_m.pop_front();
               n_out++;
               if ({m.sum, m.c_out, m.ovf} !== {e.sum, e.c, e.v}) begin
                  bad++;
                  $display("FAIL result32: got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                           m.sum, m.c_out, m.ovf, e.sum, e.c, e.v);
               end
            end
         end
         stalled  = m.out_valid && !m.out_ready;
         held.sum = m.sum;
         held.c   = m.c_out;
         held.v   = m.ovf;
         occ = occ + int'(m.in_valid && m.in_ready) - int'(m.out_valid && m.out_ready);
      end
   end

   // ---------------- sweep DUT monitors ----------------
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q16.delete();
      end else if (s16.out_valid && s16.out_ready) begin
         total++;
         if (q16.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat16: got sum=%h want no beat", s16.sum);
         end else begin
            e = q16.pop_front();
            if ({s16.sum, s16.c_out, s16.ovf} !== {e.sum[15:0], e.c, e.v}) begin
               bad++;
               $display("FAIL result16: got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                        s16.sum, s16.c_out, s16.ovf, e.sum[15:0], e.c, e.v);
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q24.delete();
      end else if (s24.out_valid && s24.out_ready) begin
         total++;
         if (q24.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat24: got sum=%h want no beat", s24.sum);
         end else begin
            e = q24.pop_front();
            if ({s24.sum, s24.c_out, s24.ovf} !== {e.sum[23:0], e.c, e.v}) begin
               bad++;
               $display("FAIL result24: got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                        s24.sum, s24.c_out, s24.ovf, e.sum[23:0], e.c, e.v);
            end
         end
      end
   end

   // ---------------- drivers ----------------
   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_m(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
      m.in_valid = 1'b1;
      m.a = a;  m.b = b;  m.c_in = ci;  m.sub = sb;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (m.in_ready) begin
            q_m.push_back(model(32, a, b, ci, sb));
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
      end
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles want 1");
   endtask

   task automatic send_s(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
      s16.in_valid = 1'b1;  s24.in_valid = 1'b1;
      s16.a = a[15:0];  s16.b = b[15:0];  s16.c_in = ci;  s16.sub = sb;
      s24.a = a[23:0];  s24.b = b[23:0];  s24.c_in = ci;  s24.sub = sb;
      @(negedge clk);
      total++;
      if ({s16.in_ready, s24.in_ready} !== 2'b11) begin
         bad++;
         $display("FAIL sweep_in_ready: got %b%b want 11", s16.in_ready, s24.in_ready);
      end
      q16.push_back(model(16, a, b, ci, sb));
      q24.push_back(model(24, a, b, ci, sb));
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && q_m.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      total++;
      if (q_m.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", q_m.size());
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      #12;
      total++;
      if ({m.out_valid, m.sum, m.c_out, m.ovf} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_state: got v=%b sum=%h c=%b o=%b want v=0 sum=0 c=0 o=0",
                  m.out_valid, m.sum, m.c_out, m.ovf);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      total++;
      if ({m.in_ready, s16.in_ready, s24.in_ready} !== 3'b111) begin
         bad++;
         $display("FAIL reset_ready: got %b%b%b want 111", m.in_ready, s16.in_ready, s24.in_ready);
      end
      idle(1);
   endtask

   task automatic test_carry_through();
      int lat;
      m.out_ready = 1'b1;
      send_m(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      m.in_valid = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m.out_valid) break;
         @(posedge clk);
         lat++;
      end
      total++;
      if (lat != LAT_M - 1) begin
         bad++;
         $display("FAIL latency: got %0d edges after accept want %0d", lat, LAT_M - 1);
      end
      total++;
      if ({m.sum, m.c_out, m.ovf} !== {32'h0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL carry_through: got sum=%h c=%b o=%b want sum=00000000 c=1 o=0",
                  m.sum, m.c_out, m.ovf);
      end
      wait_drain();
   endtask

   task automatic test_directed();
      m.out_ready = 1'b1;
      send_m(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
      send_m(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
      send_m(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1);
      send_m(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      send_m(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
      send_m(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
      m.in_valid = 1'b0;
      wait_drain();
   endtask

   task automatic test_back_to_back();
      int start;
      start = n_out;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               send_m($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
            end
            m.in_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 120; i++) begin
               m.out_ready = (i % 3 == 0);
               @(posedge clk);
               #1;
            end
         end
      join
      m.out_ready = 1'b1;
      wait_drain();
      total++;
      if (n_out - start != 20) begin
         bad++;
         $display("FAIL stream_count: got %0d beats want 20", n_out - start);
      end
   endtask

   task automatic test_reset_mid();
      int start;
      m.out_ready = 1'b0;
      send_m(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
      send_m(32'h0000_3333, 32'h0000_4444, 1'b0, 1'b0);
      send_m(32'h0000_5555, 32'h0000_6666, 1'b0, 1'b0);
      m.in_valid = 1'b0;
      idle(1);
      total++;
      if (m.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset_valid: got %b want 1", m.out_valid);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({m.out_valid, m.sum} !== {1'b0, 32'h0}) begin
         bad++;
         $display("FAIL mid_reset: got v=%b sum=%h want v=0 sum=0", m.out_valid, m.sum);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      m.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if (m.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stale_beat: got out_valid=%b want 0", m.out_valid);
         end
         @(posedge clk);
         #1;
      end
      start = n_out;
      send_m(32'hDEAD_BEEF, 32'h0000_0011, 1'b1, 1'b0);
      m.in_valid = 1'b0;
      wait_drain();
      total++;
      if (n_out - start != 1) begin
         bad++;
         $display("FAIL post_reset_count: got %0d beats want 1", n_out - start);
      end
   endtask

   task automatic test_sweep();
      s16.out_ready = 1'b1;
      s24.out_ready = 1'b1;
      send_s(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      s16.in_valid = 1'b0;
      s24.in_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({s16.out_valid, s24.out_valid} !== 2'b10) begin
         bad++;
         $display("FAIL sweep_latency1: got %b%b want 10", s16.out_valid, s24.out_valid);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if (s24.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL sweep_latency2: got %b want 1", s24.out_valid);
      end
      @(posedge clk);
      #1;
      send_s(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      send_s(32'h0080_8000, 32'h0000_0001, 1'b0, 1'b1);
      send_s(32'h007F_7FFF, 32'h0000_0000, 1'b1, 1'b0);
      send_s(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1);
      for (int i = 0; i < 40; i++) begin
         send_s($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
      end
      s16.in_valid = 1'b0;
      s24.in_valid = 1'b0;
      idle(5);
      total++;
      if (q16.size() + q24.size() != 0) begin
         bad++;
         $display("FAIL sweep_drain: got %0d/%0d pending want 0/0", q16.size(), q24.size());
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      n_out = 0;
      occ   = 0;
      stalled = 1'b0;
      held  = '0;
      m.in_valid = 1'b0;  m.a = '0;  m.b = '0;  m.c_in = 1'b0;  m.sub = 1'b0;  m.out_ready = 1'b1;
      s16.in_valid = 1'b0;  s16.a = '0;  s16.b = '0;  s16.c_in = 1'b0;  s16.sub = 1'b0;  s16.out_ready = 1'b1;
      s24.in_valid = 1'b0;  s24.a = '0;  s24.b = '0;  s24.c_in = 1'b0;  s24.sub = 1'b0;  s24.out_ready = 1'b1;

      test_reset();
      test_carry_through();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      test_sweep();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
